dual_core_init_sequencer: RTL and testbench
===========================================

Name: dual_core_init_sequencer

Overview:
- Sequences lockstep bring-up of the two sodor5 core copies (core/model instance 1 and 2) inside the sodor5 verification wrapper.
- Holds both copies stalled while it writes identical pseudo-random contents into each register file (32 entries), then each dmem (16 words), over a shared write bus.
- Then releases the cores for a fixed run window and reports done.
- Replaces hierarchical-reference initialisation with a synthesizable, formally usable sequencer.

Parameters:
- XLEN, 32, data width of regfile/dmem words.
- NREGS, 32, regfile entries written (x0 included).
- NDMEM, 16, dmem words written.
- RUN_CYCLES, 30, cycles cores run unstalled after init; 0 legal.
- LFSR_POLY, 32'h80200003, Galois feedback mask.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence.
- seed  in  XLEN  LFSR seed, sampled with start.
- init_wr_valid  out  1  write beat valid.
- init_wr_target  out  1  0 = regfile, 1 = dmem.
- init_wr_addr  out  5  entry index.
- init_wr_data  out  XLEN  write data.
- init_wr_ready1  in  1  copy 1 accepts beat.
- init_wr_ready2  in  1  copy 2 accepts beat.
- core_stall  out  1  stalls both copies while high.
- cycle_count  out  32  run cycles elapsed.
- busy  out  1  high in INIT_RF, INIT_DMEM and RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; init_wr_valid=0, target=0, addr=0, data=0, core_stall=1, cycle_count=0, busy=0, done=0. Reset mid-sequence aborts immediately to these values; no partial-state resume.
- LFSR step: next(x) = (x>>1) ^ (x[0] ? LFSR_POLY : 0). A seed of 0 is replaced by 1.
- States and transitions:
  - IDLE: start=1 at edge T. Latch the seed. Next state INIT_RF. From T+1: valid=1, target=0, addr=0, data=next(seed).
  - Transfer: a beat transfers only on a cycle with valid & ready1 & ready2.
    - If either ready is low, valid, target, addr and data hold stable. No copy sees a beat the other did not.
    - On transfer: addr+1 and data=next(data). The LFSR runs continuously across the regfile to dmem boundary.
  - INIT_RF: transfer at addr NREGS-1 goes to INIT_DMEM with addr=0, target=1.
  - INIT_DMEM: transfer at addr NDMEM-1 goes to RUN.
    - valid=0 and core_stall=0 from the next cycle.
    - If RUN_CYCLES=0, go directly to DONE with stall held at 1.
  - RUN: cycle_count increments every cycle. When cycle_count==RUN_CYCLES-1, the next state is DONE: core_stall=1, done=1, and cycle_count holds RUN_CYCLES.
  - DONE: done held. start restarts the sequence as from IDLE, clearing cycle_count and done on entry to INIT_RF.
- start is ignored while busy=1.
- Data sequence: regfile entries 0..NREGS-1, then dmem 0..NDMEM-1, take consecutive LFSR states.
- Minimum latency with both readies tied high: NREGS+NDMEM beat cycles + RUN_CYCLES + 1.

Decomposition:
- Package sodor_init_pkg:
  - state enum {IDLE, INIT_RF, INIT_DMEM, RUN, DONE}.
  - target enum {TGT_RF, TGT_DMEM}.
  - LFSR_POLY default.
  - lfsr_next function.
- One sub-module, init_lfsr: seed load, zero-seed fix, and advance-on-enable, with a registered output.
- FSM, address counter and run counter stay in dual_core_init_sequencer.

Test Plan:
- Reset, start=0 → valid=0, stall=1, busy=0, done=0, cycle_count=0, held for 10 cycles.
- seed=1, start at T, readies tied 1 → T+1: addr0 target0 data 0x80200003. T+2: addr1 data 0xC0300002. 48 beats total; target flips to 1 at beat 33. stall=0 at T+49; done=1 at T+79; cycle_count=30.
- Same run with ready2=0 for 3 cycles during beat 5 → beat 5 fields stable for 4 cycles; sequence resumes identical, completion 3 cycles later.
- seed=0 → identical beat data to the seed=1 case.
- rst_n asserted low mid INIT_DMEM (beat 40) → all outputs at reset values the same cycle. Fresh start replays from beat 0.
- start pulsed during RUN → ignored. start in DONE → restart, cycle_count=0, done=0. RUN_CYCLES=0 build → DONE one cycle after the last dmem beat, stall never drops.

Source files
------------

// File: rtl/sodor_init_pkg.sv
// Shared types and LFSR step for the dual-core lockstep init sequencer.
package sodor_init_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;

  // Explicit encodings keep the state values identical to the legacy localparams.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_RF   = 3'd1,
    INIT_DMEM = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef enum logic {
    TGT_RF   = 1'b0,
    TGT_DMEM = 1'b1
  } target_t;

  // Galois step: shift right, fold the feedback mask in when the dropped bit is set.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] poly);
    return (x >> 1) ^ (x[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/init_lfsr.sv
// Seeded Galois LFSR; the loaded value is already one step past the seed.
module init_lfsr
  import sodor_init_pkg::*;
#(
  parameter int unsigned     XLEN = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] POLY = XLEN'(LFSR_POLY_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] seed,
  input  logic            advance,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] seed_fix;

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  assign seed_fix = (seed == '0) ? XLEN'(1) : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= XLEN'(lfsr_next(32'(seed_fix), 32'(POLY)));
    end else if (advance) begin
      value <= XLEN'(lfsr_next(32'(value), 32'(POLY)));
    end
  end

endmodule

// File: rtl/dual_core_init_sequencer.sv
// Lockstep bring-up of two core copies: stalled init of regfile and dmem over a
// shared write bus, then a fixed unstalled run window.
module dual_core_init_sequencer
  import sodor_init_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter int unsigned     NREGS      = 32,
  parameter int unsigned     NDMEM      = 16,
  parameter int unsigned     RUN_CYCLES = 30,
  parameter logic [XLEN-1:0] LFSR_POLY  = XLEN'(LFSR_POLY_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] seed,
  output logic            init_wr_valid,
  output logic            init_wr_target,
  output logic [4:0]      init_wr_addr,
  output logic [XLEN-1:0] init_wr_data,
  input  logic            init_wr_ready1,
  input  logic            init_wr_ready2,
  output logic            core_stall,
  output logic [31:0]     cycle_count,
  output logic            busy,
  output logic            done
);

  localparam logic [4:0]  LAST_RF  = 5'(NREGS - 1);
  localparam logic [4:0]  LAST_DM  = 5'(NDMEM - 1);
  localparam logic [31:0] RUN_LAST = (RUN_CYCLES == 0) ? 32'd0 : 32'(RUN_CYCLES - 1);

  state_t      state;
  logic [4:0]  addr;
  logic [31:0] count;
  logic        accept_start;
  logic        xfer;

  assign accept_start = start && ((state == IDLE) || (state == DONE));

  // A beat only moves when both copies accept it, keeping them in lockstep.
  assign xfer = init_wr_valid && init_wr_ready1 && init_wr_ready2;

  assign init_wr_valid  = (state == INIT_RF) || (state == INIT_DMEM);
  assign init_wr_target = (state == INIT_DMEM) ? TGT_DMEM : TGT_RF;
  assign init_wr_addr   = addr;
  assign core_stall     = (state != RUN);
  assign busy           = (state == INIT_RF) || (state == INIT_DMEM) || (state == RUN);
  assign done           = (state == DONE);
  assign cycle_count    = count;

  // Sequencer state, write-bus address and run-window counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept_start) begin
            state <= INIT_RF;
            addr  <= '0;
            count <= '0;
          end
        end
        INIT_RF: begin
          if (xfer) begin
            if (addr == LAST_RF) begin
              state <= INIT_DMEM;
              addr  <= '0;
            end else begin
              addr <= addr + 5'd1;
            end
          end
        end
        INIT_DMEM: begin
          if (xfer) begin
            if (addr == LAST_DM) begin
              state <= (RUN_CYCLES == 0) ? DONE : RUN;
              addr  <= '0;
            end else begin
              addr <= addr + 5'd1;
            end
          end
        end
        RUN: begin
          count <= count + 32'd1;
          if (count == RUN_LAST) begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  init_lfsr #(
    .XLEN (XLEN),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept_start),
    .seed    (seed),
    .advance (xfer),
    .value   (init_wr_data)
  );

endmodule

// File: tb/tb_dual_core_init_sequencer.sv
// Directed bench for dual_core_init_sequencer (RUN_CYCLES=30 and RUN_CYCLES=0 builds).
module tb_dual_core_init_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_z = 1'b0;
  logic [31:0] seed = '0;
  logic        ready1 = 1'b1;
  logic        ready2 = 1'b1;

  logic        valid, target, stall, busy, done;
  logic [4:0]  addr;
  logic [31:0] data, count;

  logic        zvalid, ztarget, zstall, zbusy, zdone;
  logic [4:0]  zaddr;
  logic [31:0] zdata, zcount;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dual_core_init_sequencer #(.RUN_CYCLES(30)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .seed           (seed),
    .init_wr_valid  (valid),
    .init_wr_target (target),
    .init_wr_addr   (addr),
    .init_wr_data   (data),
    .init_wr_ready1 (ready1),
    .init_wr_ready2 (ready2),
    .core_stall     (stall),
    .cycle_count    (count),
    .busy           (busy),
    .done           (done)
  );

  dual_core_init_sequencer #(.RUN_CYCLES(0)) dut_z (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_z),
    .seed           (seed),
    .init_wr_valid  (zvalid),
    .init_wr_target (ztarget),
    .init_wr_addr   (zaddr),
    .init_wr_data   (zdata),
    .init_wr_ready1 (1'b1),
    .init_wr_ready2 (1'b1),
    .core_stall     (zstall),
    .cycle_count    (zcount),
    .busy           (zbusy),
    .done           (zdone)
  );

  typedef struct {
    int          cyc;
    logic        valid;
    logic        chk_ta;
    logic        target;
    logic [4:0]  addr;
    logic        chk_d;
    logic [31:0] data;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] model_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic void add(input int cyc, input logic v, input logic cta, input logic t,
                              input logic [4:0] a, input logic cd, input logic [31:0] d,
                              input logic s, input logic b, input logic dn, input logic [31:0] c);
    vec_t e;
    e.cyc = cyc; e.valid = v; e.chk_ta = cta; e.target = t; e.addr = a;
    e.chk_d = cd; e.data = d; e.stall = s; e.busy = b; e.done = dn; e.cnt = c;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " valid"},  32'(valid),  32'd0);
    chk({tag, " target"}, 32'(target), 32'd0);
    chk({tag, " addr"},   32'(addr),   32'd0);
    chk({tag, " data"},   data,        32'd0);
    chk({tag, " stall"},  32'(stall),  32'd1);
    chk({tag, " count"},  count,       32'd0);
    chk({tag, " busy"},   32'(busy),   32'd0);
    chk({tag, " done"},   32'(done),   32'd0);
  endtask

  // Cycle c=1 is the cycle right after the edge that samples start.
  task automatic run_sequence(input logic [31:0] sd, input int stall_len,
                              input int pulse_cyc, input logic hand_data);
    logic [31:0] expd[48];
    logic [31:0] x;
    int b, rem, hold, shift;
    x = (sd == 32'd0) ? 32'd1 : sd;
    for (int i = 0; i < 48; i++) begin
      x = model_step(x);
      expd[i] = x;
    end
    b = 0; rem = stall_len; hold = 0;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 84 + stall_len; c++) begin
      start = (c == pulse_cyc);
      if (c == pulse_cyc) seed = 32'hFFFF_FFFF;
      if (b == 4 && rem > 0) begin
        ready2 = 1'b0;
        rem--;
      end else begin
        ready2 = 1'b1;
      end
      foreach (tbl[i]) begin
        shift = (tbl[i].cyc >= 5) ? stall_len : 0;
        if (tbl[i].cyc + shift == c) begin
          chk($sformatf("c%0d valid", c), 32'(valid), 32'(tbl[i].valid));
          chk($sformatf("c%0d stall", c), 32'(stall), 32'(tbl[i].stall));
          chk($sformatf("c%0d busy", c),  32'(busy),  32'(tbl[i].busy));
          chk($sformatf("c%0d done", c),  32'(done),  32'(tbl[i].done));
          chk($sformatf("c%0d count", c), count,      tbl[i].cnt);
          if (tbl[i].chk_ta) begin
            chk($sformatf("c%0d target", c), 32'(target), 32'(tbl[i].target));
            chk($sformatf("c%0d addr", c),   32'(addr),   32'(tbl[i].addr));
          end
          if (tbl[i].chk_d && hand_data) begin
            chk($sformatf("c%0d data", c), data, tbl[i].data);
          end
        end
      end
      if (valid) begin
        if (b < 48) begin
          chk($sformatf("beat%0d fields", b), {data, 26'(0), target, addr},
              {expd[b], 26'(0), (b >= 32) ? 1'b1 : 1'b0, 5'((b >= 32) ? b - 32 : b)});
        end else begin
          chk("beat overflow", 32'(b), 32'd47);
        end
        if (!target && addr == 5'd4) hold++;
        if (ready1 && ready2) b++;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    ready2 = 1'b1;
    chk("beat total", 32'(b), 32'd48);
    if (stall_len > 0) chk("beat5 hold cycles", 32'(hold), 32'(stall_len + 1));
  endtask

  task automatic mid_reset;
    logic [31:0] x;
    x = 32'd1;
    for (int i = 0; i < 40; i++) x = model_step(x);
    @(negedge clk);
    seed  = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("beat40 valid",  32'(valid),  32'd1);
    chk("beat40 target", 32'(target), 32'd1);
    chk("beat40 addr",   32'(addr),   32'd7);
    chk("beat40 data",   data,        x);
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk);
    check_reset_values("reset held");
    rst_n = 1'b1;
  endtask

  task automatic run_zero_build;
    int lows, beats;
    lows = 0; beats = 0;
    @(negedge clk);
    seed    = 32'd1;
    start_z = 1'b1;
    @(negedge clk);
    start_z = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      if (!zstall) lows++;
      if (zvalid) beats++;
      if (c == 48) begin
        chk("z c48 valid",  32'(zvalid),  32'd1);
        chk("z c48 target", 32'(ztarget), 32'd1);
        chk("z c48 addr",   32'(zaddr),   32'd15);
        chk("z c48 done",   32'(zdone),   32'd0);
      end
      if (c == 49) begin
        chk("z c49 done",  32'(zdone),  32'd1);
        chk("z c49 valid", 32'(zvalid), 32'd0);
        chk("z c49 busy",  32'(zbusy),  32'd0);
        chk("z c49 count", zcount,      32'd0);
      end
      @(negedge clk);
    end
    chk("z stall drops", 32'(lows), 32'd0);
    chk("z beats",       32'(beats), 32'd48);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("in reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_values($sformatf("idle%0d", i));
      chk($sformatf("z idle%0d stall", i), 32'(zstall), 32'd1);
    end

    //  cyc  v  cta t  addr  cd data           stall busy done cnt
    add(1,   1, 1, 0, 5'd0,  1, 32'h8020_0003, 1,    1,   0,   0);
    add(2,   1, 1, 0, 5'd1,  1, 32'hC030_0002, 1,    1,   0,   0);
    add(32,  1, 1, 0, 5'd31, 0, 32'h0,         1,    1,   0,   0);
    add(33,  1, 1, 1, 5'd0,  0, 32'h0,         1,    1,   0,   0);
    add(48,  1, 1, 1, 5'd15, 0, 32'h0,         1,    1,   0,   0);
    add(49,  0, 0, 0, 5'd0,  0, 32'h0,         0,    1,   0,   0);
    add(50,  0, 0, 0, 5'd0,  0, 32'h0,         0,    1,   0,   1);
    add(78,  0, 0, 0, 5'd0,  0, 32'h0,         0,    1,   0,   29);
    add(79,  0, 0, 0, 5'd0,  0, 32'h0,         1,    0,   1,   30);
    add(84,  0, 0, 0, 5'd0,  0, 32'h0,         1,    0,   1,   30);

    run_sequence(32'd1, 0, 0, 1'b1);
    run_sequence(32'd1, 3, 0, 1'b1);
    run_sequence(32'd0, 0, 60, 1'b1);
    mid_reset();
    run_sequence(32'd1, 0, 0, 1'b1);
    run_sequence(32'hDEAD_BEEF, 0, 0, 1'b0);
    run_zero_build();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
